// File: rtl/alu_seq_pkg.sv
// Shared types for the registered sequential ALU: opcode and FSM state encodings.
package alu_seq_pkg;

  localparam int OPW_DEFAULT = 4;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    ADC = 4'd1,
    SUB = 4'd2,
    SBC = 4'd3,
    AND = 4'd4,
    OR  = 4'd5,
    XOR = 4'd6,
    LSL = 4'd7,
    LSR = 4'd8,
    ROL = 4'd9,
    ROR = 4'd10,
    ASR = 4'd11,
    PAR = 4'd12,
    CLR = 4'd13,
    MUL = 4'd14
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq; master = fetch/writeback side, slave = ALU.
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int W   = 8,
  parameter int OPW = OPW_DEFAULT
);
  logic           In_valid;
  logic           In_ready;
  logic [OPW-1:0] OP;
  logic [W-1:0]   InputA;
  logic [W-1:0]   InputB;
  logic           Out_valid;
  logic           Out_ready;
  logic [W-1:0]   Out;
  logic [W-1:0]   OutHi;
  logic           Zero;
  logic           Parity;
  logic           Odd;
  logic           SC_out;
  logic           Illegal;

  modport master (
    output In_valid, OP, InputA, InputB, Out_ready,
    input  In_ready, Out_valid, Out, OutHi, Zero, Parity, Odd, SC_out, Illegal
  );

  modport slave (
    input  In_valid, OP, InputA, InputB, Out_ready,
    output In_ready, Out_valid, Out, OutHi, Zero, Parity, Odd, SC_out, Illegal
  );
endinterface

// File: rtl/alu_seq_mul_shift_add.sv
// Unsigned W x W iterative multiplier: one shift-add step per clock, W steps after start.
module mul_shift_add #(
  parameter int W = 8
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W);

  logic           active;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc;

  // done flags the edge that performs the final step; acc is complete right after it
  assign done    = active && (cnt == CW'(W - 1));
  assign product = acc;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      active <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      mcand  <= {{W{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
    end else if (active) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and persistent carry C.
// Define ALU_MUL_EN to compile in the iterative MUL (BUSY/DONE states + mul_shift_add).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W   = 8,
  parameter int OPW = OPW_DEFAULT
) (
  input  logic      Clk,
  input  logic      Reset_n,
  alu_seq_if.slave  bus
);

  localparam int OP_BITS = $bits(alu_op_t);

  typedef struct packed {
    logic [W-1:0] out;
    logic         c;
    logic         illegal;
    logic         is_mul;
  } alu_res_t;

  // W+1-bit arithmetic: the extra MSB becomes the new carry.
  function automatic alu_res_t alu_calc(input logic [OPW-1:0] op_code,
                                        input logic [W-1:0]   a,
                                        input logic [W-1:0]   b,
                                        input logic           c_in);
    alu_res_t            r;
    logic [W:0]          sum;
    logic signed [W-1:0] a_s;
    r.out     = '0;
    r.c       = c_in;
    r.illegal = 1'b0;
    r.is_mul  = 1'b0;
    sum       = '0;
    a_s       = $signed(a);
    if (op_code > OPW'(MUL)) begin
      r.illegal = 1'b1;
    end else begin
      case (alu_op_t'(op_code[OP_BITS-1:0]))
        ADD: begin sum = {1'b0, a} + {1'b0, b};                        {r.c, r.out} = sum; end
        ADC: begin sum = {1'b0, a} + {1'b0, b} + (W+1)'(c_in);         {r.c, r.out} = sum; end
        SUB: begin sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);           {r.c, r.out} = sum; end
        SBC: begin sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(c_in);        {r.c, r.out} = sum; end
        AND: r.out = a & b;
        OR:  r.out = a | b;
        XOR: r.out = a ^ b;
        LSL: begin r.c = a[W-1]; r.out = {a[W-2:0], 1'b0}; end
        LSR: begin r.c = a[0];   r.out = {1'b0, a[W-1:1]}; end
        ROL: {r.c, r.out} = {a, c_in};
        ROR: {r.out, r.c} = {c_in, a};
        ASR: begin r.c = a[0];   r.out = a_s >>> 1; end
        PAR: r.out = {^a[W-2:0], {(W-1){1'b0}}};
        CLR: begin r.c = 1'b0;   r.out = '0; end
`ifdef ALU_MUL_EN
        MUL: r.is_mul = 1'b1;
`else
        MUL: r.illegal = 1'b1;
`endif
        default: r.illegal = 1'b1;
      endcase
    end
    return r;
  endfunction

  alu_state_t   state;
  alu_res_t     res;
  logic         accept;
  logic         in_ready;
  logic         wr_en;
  logic [W-1:0] wr_out;
  logic         wr_c;
  logic         wr_ill;

  logic [W-1:0] out_p1;
  logic         vld_p1;
  logic         zero_p1;
  logic         parity_p1;
  logic         odd_p1;
  logic         illegal_p1;
  logic         carry;

  assign res      = alu_calc(bus.OP, bus.InputA, bus.InputB, carry);
  assign in_ready = (state == IDLE) && (!vld_p1 || bus.Out_ready);
  assign accept   = bus.In_valid && in_ready;

`ifdef ALU_MUL_EN
  logic           mul_done;
  logic [2*W-1:0] mul_prod;
  logic [W-1:0]   wr_hi;
  logic [W-1:0]   out_hi_p1;

  mul_shift_add #(.W(W)) u_mul (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (accept && res.is_mul),
    .A       (bus.InputA),
    .B       (bus.InputB),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign bus.OutHi = out_hi_p1;
`else
  assign state     = IDLE;
  assign bus.OutHi = '0;
`endif

  // Result-register write source: single-cycle op at accept, or the finished product in DONE
  always_comb begin
    wr_en  = accept && !res.is_mul;
    wr_out = res.out;
    wr_c   = res.c;
    wr_ill = res.illegal;
`ifdef ALU_MUL_EN
    wr_hi  = '0;
    if (state == DONE) begin
      wr_en  = 1'b1;
      wr_out = mul_prod[W-1:0];
      wr_hi  = mul_prod[2*W-1:W];
      wr_c   = |mul_prod[2*W-1:W];
      wr_ill = 1'b0;
    end
`endif
  end

  // Stage p1: result/flag registers, carry and FSM
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vld_p1     <= 1'b0;
      out_p1     <= '0;
      zero_p1    <= 1'b1;
      parity_p1  <= 1'b0;
      odd_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      carry      <= 1'b0;
`ifdef ALU_MUL_EN
      state      <= IDLE;
      out_hi_p1  <= '0;
`endif
    end else begin
      if (bus.Out_ready) vld_p1 <= 1'b0;
      if (wr_en) begin
        vld_p1     <= 1'b1;
        out_p1     <= wr_out;
        zero_p1    <= ~|wr_out;
        parity_p1  <= ^wr_out;
        odd_p1     <= wr_out[0];
        illegal_p1 <= wr_ill;
        carry      <= wr_c;
`ifdef ALU_MUL_EN
        out_hi_p1  <= wr_hi;
`endif
      end
`ifdef ALU_MUL_EN
      case (state)
        IDLE:    if (accept && res.is_mul) state <= BUSY;
        BUSY:    if (mul_done) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
`endif
    end
  end

  assign bus.In_ready  = in_ready;
  assign bus.Out_valid = vld_p1;
  assign bus.Out       = out_p1;
  assign bus.Zero      = zero_p1;
  assign bus.Parity    = parity_p1;
  assign bus.Odd       = odd_p1;
  assign bus.SC_out    = carry;
  assign bus.Illegal   = illegal_p1;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU with a valid/ready handshake on both sides and a persistent carry flag for multi-precision arithmetic. It also performs an optional iterative multiply: W+1 cycles, double-width result. It replaces the purely combinational datapath ALU wherever the core needs back-pressure, carries chained across instructions, or a multiply. It sits between operand fetch and writeback.

## Interface
- W, 8: operand/result width, 4..32.
- OPW, 4: opcode width; must hold every `alu_op_t` value.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous, active-low reset. Sampled on the Clk rising edge.
- In_valid  in  1  operands and opcode valid.
- In_ready  out  1  block accepts this cycle.
- OP  in  OPW  opcode, `alu_op_t`.
- InputA, InputB  in  W  operands.
- Out_valid  out  1  result registers valid.
- Out_ready  in  1  consumer takes result.
- Out  out  W  result, low half for MUL.
- OutHi  out  W  MUL high half; 0 for all other ops.
- Zero, Parity, Odd  out  1  ~|Out, ^Out, Out[0]; registered with Out.
- SC_out  out  1  current carry register C.
- Illegal  out  1  result came from an undefined opcode.

## Operation
- Accept when In_valid && In_ready.
- In_ready = (state==IDLE) && (!Out_valid || Out_ready). A new op can be accepted in the same cycle the previous result is consumed.
- States:
  - IDLE: single-cycle ops write the result registers at the accept edge.
  - MUL accept → BUSY.
  - BUSY: one shift-add step per cycle, W steps, then → DONE.
  - DONE: load Out/OutHi/flags, assert Out_valid → IDLE.
- Out_valid clears on Out_ready unless a new result is written in the same cycle. While Out_ready is low, every output is held stable.
- C (carry register) updates only when the result registers are written:
  - ADD: {C,Out}=A+B.
  - ADC: {C,Out}=A+B+C.
  - SUB: {C,Out}=A+~B+1. C=1 means no borrow.
  - SBC: {C,Out}=A+~B+C.
  - LSL: C=A[W-1], Out={A[W-2:0],0}.
  - LSR: C=A[0], Out={0,A[W-1:1]}.
  - ROL: {C,Out}={A,C}.
  - ROR: {Out,C}={C,A}.
  - ASR: Out={A[W-1],A[W-1:1]}, C=A[0].
  - AND/OR/XOR: bitwise; C unchanged.
  - PAR: Out={^A[W-2:0], 0...}; C unchanged.
  - CLR: Out=0, C=0.
  - MUL: {OutHi,Out}=A*B, unsigned; C=|OutHi.
- Undefined opcode: single cycle; Out=0, OutHi=0, C unchanged, Illegal=1. Illegal=0 for every legal op.
- Arithmetic is internally W+1 bits; the MSB goes to C. The multiplier accumulator is 2W bits.

## Timing
- Single-cycle op: result visible one cycle after the accept edge.
- MUL: Out_valid rises W+1 cycles after the accept edge. In_ready stays 0 throughout BUSY.
- Reset_n low at an edge sets:
  - state=IDLE
  - Out=0, OutHi=0
  - Out_valid=0, Zero=1, Parity=0, Odd=0
  - C=0, Illegal=0
  - multiplier state cleared
- Reset_n low at an edge overrides everything else, including mid-MUL and a result pending under back-pressure. The in-flight op is discarded.
- In_valid while In_ready=0 has no effect; the producer holds its inputs.
- The next op after an ADC/SBC sees C as updated by the previous op, with no bubble.

## Configuration
- ALU_MUL_EN defined: MUL, the BUSY/DONE states and the sub-module are compiled in.
- ALU_MUL_EN undefined:
  - MUL is treated as an undefined opcode (single cycle, Illegal=1).
  - OutHi is tied to 0.
  - The FSM reduces to IDLE only.

## Structure
- Package `alu_seq_pkg` holds:
  - `alu_op_t` enum (ADD, ADC, SUB, SBC, AND, OR, XOR, LSL, LSR, ROL, ROR, ASR, PAR, CLR, MUL).
  - `alu_state_t` enum (IDLE, BUSY, DONE).
  - OPW default.
- Sub-module `mul_shift_add` #(W) contains:
  - Interface: start, A, B in; done, product[2W-1:0] out.
  - Internals: step counter, multiplicand/multiplier/accumulator registers, same Clk/Reset_n.
  - Instantiated only under ALU_MUL_EN.

## Test plan
All scenarios use W=8.
- Carry chain: ADD 0xFF,0x01 → Out=0x00, Zero=1, C=1. Then ADC 0x00,0x00 → Out=0x01, C=0.
- Borrow: SUB 0x05,0x07 → Out=0xFE, C=0, Parity=1. Then SBC 0x00,0x00 → Out=0xFF, C=0.
- MUL: 0xFF×0xFF accepted at cycle t.
  - Out_valid first high at t+9, with Out=0x01, OutHi=0xFE, C=1.
  - In_ready=0 for cycles t+1..t+8.
- Back-pressure: Out_ready=0 for 5 cycles after XOR 0xA5,0x0F.
  - Out=0xAA is held and In_ready=0.
  - On Out_ready=1 with In_valid=1, the next op is accepted in the same cycle.
- Reset mid-MUL: Reset_n=0 at t+4 of a MUL.
  - The next edge shows Out_valid=0, C=0, In_ready=1.
  - A following ADD 0x02,0x03 gives 0x05 one cycle later.
- Undefined opcode 0xF → Out=0, Illegal=1, C unchanged. Without ALU_MUL_EN, MUL behaves the same.
